// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge port of the MEM stage.
//   req   : access request, held until ack or abort
//   we    : 1 = store, 0 = load
//   addr  : byte address of the word access
//   wdata : store data
//   rdata : load data, valid while ack is high
//   ack   : memory completes the access this cycle
// master: pipeline side (memory_stage); slave: memory side.
interface memory_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/memory_stage.sv
// MEM stage of a 5-stage MIPS pipeline. It takes the XM_* register from execute, performs loads
// and stores over a req/ack memory port, and produces the MW_* register for write-back.
//   clk, rst           : clock and synchronous active-high reset
//   XM_*, ALUout       : execute/memory pipeline register contents
//   dm                 : data-memory port (memory_stage_if.master)
//   mem_stall          : holds IF/ID/EX/XM while an access is outstanding
//   branch_taken/target: branch decision forwarded straight to fetch
//   MW_*               : memory/write-back pipeline register
//   bus_err            : sticky, an access timed out
//   misalign_err       : sticky, a memory op used a non-word-aligned address
//   stall_cycles       : free-running count of stalled cycles (wraps)
module memory_stage #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  XM_MemtoReg,
  input  logic                  XM_RegWrite,
  input  logic                  XM_MemRead,
  input  logic                  XM_MemWrite,
  input  logic                  XM_branch,
  input  logic [31:0]           XM_BT,
  input  logic [31:0]           ALUout,
  input  logic [4:0]            XM_RD,
  input  logic [31:0]           XM_MD,
  memory_stage_if.master        dm,
  output logic                  mem_stall,
  output logic                  branch_taken,
  output logic [31:0]           branch_target,
  output logic                  MW_MemtoReg,
  output logic                  MW_RegWrite,
  output logic [31:0]           MW_ALUout,
  output logic [31:0]           MW_MDR,
  output logic [4:0]            MW_RD,
  output logic                  bus_err,
  output logic                  misalign_err,
  output logic [CNT_W-1:0]      stall_cycles
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [7:0]        timer_q, timer_d;
  logic              mw_mtr_q, mw_mtr_d;
  logic              mw_rw_q, mw_rw_d;
  logic [31:0]       mw_alu_q, mw_alu_d;
  logic [31:0]       mw_mdr_q, mw_mdr_d;
  logic [4:0]        mw_rd_q, mw_rd_d;
  logic              bus_err_q, bus_err_d;
  logic              misalign_q, misalign_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic mem_op, aligned, is_load, timer_last;

  always_comb begin
    mem_op     = XM_MemRead | XM_MemWrite;
    aligned    = (ALUout[1:0] == 2'b00);
    // MemRead together with MemWrite is treated as a store.
    is_load    = XM_MemRead & ~XM_MemWrite;
    timer_last = (timer_q == TimerLast);

    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    timer_d    = timer_q;
    bus_err_d  = bus_err_q;
    misalign_d = misalign_q;
    mem_stall  = 1'b0;

    // Bubble by default: WB must not write while XM is held.
    mw_mtr_d   = 1'b0;
    mw_rw_d    = 1'b0;
    mw_rd_d    = 5'd0;
    mw_alu_d   = ALUout;
    mw_mdr_d   = 32'd0;

    unique case (state_q)
      StIdle: begin
        if (!mem_op) begin
          mw_mtr_d = XM_MemtoReg;
          mw_rw_d  = XM_RegWrite;
          mw_rd_d  = XM_RD;
        end else if (!aligned) begin
          misalign_d = 1'b1;
        end else begin
          mem_stall = 1'b1;
          state_d   = StBusy;
          req_d     = 1'b1;
          we_d      = XM_MemWrite;
          addr_d    = ALUout;
          wdata_d   = XM_MD;
          timer_d   = 8'd0;
        end
      end
      StBusy: begin
        if (dm.ack) begin
          // Ack wins over a same-cycle timeout.
          state_d  = StIdle;
          req_d    = 1'b0;
          mw_mtr_d = XM_MemtoReg;
          mw_rw_d  = XM_RegWrite;
          mw_rd_d  = XM_RD;
          mw_mdr_d = is_load ? dm.rdata : 32'd0;
        end else if (timer_last) begin
          // Abort: release the stall so the instruction retires as a bubble.
          state_d   = StIdle;
          req_d     = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          mem_stall = 1'b1;
          timer_d   = timer_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    stall_cnt_d = stall_cnt_q + CNT_W'(mem_stall);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      timer_q     <= 8'd0;
      mw_mtr_q    <= 1'b0;
      mw_rw_q     <= 1'b0;
      mw_alu_q    <= 32'd0;
      mw_mdr_q    <= 32'd0;
      mw_rd_q     <= 5'd0;
      bus_err_q   <= 1'b0;
      misalign_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      timer_q     <= timer_d;
      mw_mtr_q    <= mw_mtr_d;
      mw_rw_q     <= mw_rw_d;
      mw_alu_q    <= mw_alu_d;
      mw_mdr_q    <= mw_mdr_d;
      mw_rd_q     <= mw_rd_d;
      bus_err_q   <= bus_err_d;
      misalign_q  <= misalign_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dm.req        = req_q;
  assign dm.we         = we_q;
  assign dm.addr       = addr_q;
  assign dm.wdata      = wdata_q;
  assign branch_taken  = XM_branch;
  assign branch_target = XM_BT;
  assign MW_MemtoReg   = mw_mtr_q;
  assign MW_RegWrite   = mw_rw_q;
  assign MW_ALUout     = mw_alu_q;
  assign MW_MDR        = mw_mdr_q;
  assign MW_RD         = mw_rd_q;
  assign bus_err       = bus_err_q;
  assign misalign_err  = misalign_q;
  assign stall_cycles  = stall_cnt_q;

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
MEM stage of the 5-stage MIPS pipeline; consumes the XM_* pipeline register produced by the execute stage and produces the MW_* register read by write-back.
Performs loads/stores through a req/ack data-memory port; a 2-state FSM stalls upstream until ack, with timeout.
Forwards branch decision/target from XM to fetch; flags misaligned and timed-out accesses; counts stall cycles.

Parameters:
TIMEOUT, 15, max BUSY cycles without dm_ack before abort (1..255)
CNT_W, 32, width of stall_cycles counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
XM_MemtoReg  in  1  load result selects memory data in WB
XM_RegWrite  in  1  instruction writes register file
XM_MemRead  in  1  load
XM_MemWrite  in  1  store
XM_branch  in  1  branch taken (resolved in EX)
XM_BT  in  32  branch target
ALUout  in  32  effective address / ALU result
XM_RD  in  5  destination register
XM_MD  in  32  store data
dm_rdata  in  32  memory read data, valid with dm_ack
dm_ack  in  1  memory completes access this cycle
dm_req  out  1  registered access request
dm_we  out  1  registered, 1=store
dm_addr  out  32  registered word address (byte address)
dm_wdata  out  32  registered store data
mem_stall  out  1  combinational; upstream holds IF/ID/EX/XM when 1
branch_taken  out  1  combinational = XM_branch
branch_target  out  32  combinational = XM_BT
MW_MemtoReg  out  1  registered
MW_RegWrite  out  1  registered
MW_ALUout  out  32  registered ALU result
MW_MDR  out  32  registered load data
MW_RD  out  5  registered destination
bus_err  out  1  sticky: access timed out
misalign_err  out  1  sticky: ALUout[1:0]!=0 on mem op
stall_cycles  out  CNT_W  cycles with mem_stall=1, wraps

Behaviour:
- Reset (sync, rst=1 at edge): state IDLE; dm_req/dm_we 0; dm_addr/dm_wdata 0; all MW_* 0; bus_err, misalign_err 0; stall_cycles 0; timeout counter 0. Reset mid-BUSY aborts access: dm_req 0 after that edge, no MW write.
- mem_op = XM_MemRead | XM_MemWrite; aligned = ALUout[1:0]==2'b00. MemRead and MemWrite both 1: treat as store.
- IDLE, no mem_op: mem_stall 0; MW_* <= XM_* (MW_ALUout<=ALUout, MW_MDR<=0); 1-cycle latency.
- IDLE, mem_op & !aligned: no request; mem_stall 0; misalign_err<=1; MW bubble (RegWrite 0, MemtoReg 0, RD 0, ALUout<=ALUout); stay IDLE.
- IDLE, mem_op & aligned: mem_stall 1; edge: state BUSY, dm_req<=1, dm_we<=XM_MemWrite, dm_addr<=ALUout, dm_wdata<=XM_MD, timer<=0, MW bubble.
- BUSY, dm_ack=0: mem_stall 1; dm_* held; timer+1; MW bubble. If timer==TIMEOUT-1 on this cycle: edge -> IDLE, dm_req<=0, bus_err<=1, MW bubble; mem_stall 0 this cycle so instruction retires (load writes nothing).
- BUSY, dm_ack=1: mem_stall 0; edge -> IDLE, dm_req<=0; MW_MemtoReg/RegWrite/RD/ALUout <= XM values (upstream held); MW_MDR<=dm_rdata for load, 0 for store. Ack and timeout same cycle: ack wins, no bus_err.
- dm_ack while IDLE ignored.
- Minimum memory op: 2 cycles in MEM (1 stall + ack cycle). Back-to-back mem ops: second enters IDLE the cycle after ack, issues fresh request.
- mem_stall = (IDLE & mem_op & aligned) | (BUSY & !dm_ack & timer!=TIMEOUT-1).
- stall_cycles +1 each edge where mem_stall=1 (not during rst); wraps modulo 2^CNT_W.
- Bubble cycles keep WB from double-writing while XM is held.
- branch_taken/branch_target are pure pass-through, independent of stall.

Test Plan:
- Add pass-through: XM_RegWrite=1, ALUout=0x1234, XM_RD=5, no mem -> next cycle MW_RegWrite=1, MW_ALUout=0x1234, MW_RD=5, mem_stall never 1.
- Load, ack after 3 BUSY cycles, dm_rdata=0xDEADBEEF, ALUout=0x40, RD=8 -> dm_req=1 with dm_addr=0x40, dm_we=0; mem_stall high 4 cycles; MW_MDR=0xDEADBEEF, MW_RD=8, MW_RegWrite=1; stall_cycles=4; MW_RegWrite=0 during stall.
- Store ALUout=0x80, XM_MD=0x55AA, immediate ack -> dm_we=1, dm_wdata=0x55AA, 1 stall cycle, MW_RegWrite=0, MW_MDR=0.
- Load to ALUout=0x42 -> no dm_req, misalign_err=1, MW_RegWrite=0, mem_stall 0.
- Load with no ack, TIMEOUT=15 -> dm_req high 15 cycles then 0, bus_err=1, MW_RegWrite=0; ack on cycle 15 instead -> bus_err stays 0.
- rst asserted 2nd BUSY cycle -> next edge dm_req=0, all MW_* 0, stall_cycles=0; XM_branch=1, XM_BT=0x100 -> branch_taken=1, branch_target=0x100 same cycle.
